// File: rtl/fp_pkg.sv
// Shared float-datapath definitions: IEEE-754 single-precision field widths,
// result flag bit positions, operand classes and the unpacked operand record.
package fp_pkg;

   localparam int FP_EXP_BIAS = 127;
   localparam int FP_MANT_W   = 23;
   localparam int FP_EXP_W    = 8;

   localparam int FLG_NAN = 2;
   localparam int FLG_OVF = 1;
   localparam int FLG_INX = 0;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      SUB  = 3'd1,
      NORM = 3'd2,
      INF  = 3'd3,
      NAN  = 3'd4
   } fp_class_t;

   // sh is the signed left-shift that places the significand LSB on the fixed-point grid
   typedef struct packed {
      logic             sign;
      fp_class_t        cls;
      logic [23:0]      sig;
      logic signed [9:0] sh;
   } fp_unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpack/classify of a single-precision float. Non-normal classes
// carry a zero significand so downstream shifters see no magnitude.
module fp_unpack
   import fp_pkg::*;
#(
   parameter int FRAC_W = 8
) (
   input  logic [31:0]  fp_i,
   output fp_unpacked_t unp_o
);

   logic [FP_EXP_W-1:0]  exp_s;
   logic [FP_MANT_W-1:0] man_s;

   assign exp_s = fp_i[30:23];
   assign man_s = fp_i[22:0];

   // classify operand and derive the fixed-point alignment shift
   always_comb begin
      unp_o.sign = fp_i[31];
      unp_o.sh   = 10'({2'b00, exp_s}) - 10'(FP_EXP_BIAS) + 10'(FRAC_W) - 10'(FP_MANT_W);
      unp_o.cls  = NORM;
      unp_o.sig  = {1'b1, man_s};
      if (exp_s == 8'd0) begin
         unp_o.sig = 24'd0;
         unp_o.cls = (man_s == 23'd0) ? ZERO : SUB;
      end else if (exp_s == 8'hFF) begin
         unp_o.sig = 24'd0;
         unp_o.cls = (man_s == 23'd0) ? INF : NAN;
      end else begin
         unp_o.cls = NORM;
         unp_o.sig = {1'b1, man_s};
      end
   end

endmodule

// File: rtl/fp2fix_pipe.sv
// Three-stage float-to-signed-fixed converter with valid/ready on both sides.
// Define FP2FIX_ROUND_EN for round-to-nearest-even; otherwise truncates toward zero.
module fp2fix_pipe
   import fp_pkg::*;
#(
   parameter int INT_W  = 16,
   parameter int FRAC_W = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               in_fp,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [INT_W+FRAC_W-1:0]   out_fix,
   output logic [2:0]                out_flags
);

   localparam int W  = INT_W + FRAC_W;
   localparam int MW = W + 1;
   localparam logic [MW:0]  POS_LIM = {2'b00, 1'b0, {(W-1){1'b1}}};
   localparam logic [MW:0]  NEG_LIM = {2'b00, 1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] FIX_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] FIX_MIN = {1'b1, {(W-1){1'b0}}};

   fp_unpacked_t unp_s, s1_q;
   logic         s1_v_q, s2_v_q, s3_v_q;
   logic         s1_take_s, s2_take_s, s3_take_s;

   logic          s2_sign_q;
   fp_class_t     s2_cls_q;
   logic [MW-1:0] s2_mag_q, s2_mag_d;
   logic          s2_grd_q, s2_grd_d, s2_stk_q, s2_stk_d, s2_ovf_q, s2_ovf_d;
   logic [MW+23:0] lwide_s;
   logic [49:0]    rwide_s;
   logic [9:0]     nsh_s;

   logic [MW:0]   rmag_s;
   logic          inc_s, over_s;
   logic [W-1:0]  s3_fix_q, s3_fix_d;
   logic [2:0]    s3_flg_q, s3_flg_d;

   fp_unpack #(.FRAC_W(FRAC_W)) u_unpack (.fp_i(in_fp), .unp_o(unp_s));

   // a stage loads when empty or when its contents move on this edge
   assign s3_take_s = !s3_v_q | out_ready;
   assign s2_take_s = !s2_v_q | s3_take_s;
   assign s1_take_s = !s1_v_q | s2_take_s;
   assign in_ready  = s1_take_s;

   // S2: align significand onto the fixed-point grid
   always_comb begin
      s2_mag_d = '0;
      s2_grd_d = 1'b0;
      s2_stk_d = 1'b0;
      s2_ovf_d = 1'b0;
      lwide_s  = '0;
      rwide_s  = '0;
      nsh_s    = 10'd0;
      if (!s1_q.sh[9]) begin
         if ($signed(s1_q.sh) >= $signed(10'(MW))) begin
            s2_ovf_d = |s1_q.sig;
         end else begin
            lwide_s  = {{MW{1'b0}}, s1_q.sig} << s1_q.sh[8:0];
            s2_mag_d = lwide_s[MW-1:0];
            s2_ovf_d = |lwide_s[MW+23:MW];
         end
      end else begin
         nsh_s = 10'(-$signed(s1_q.sh));
         if ($signed(s1_q.sh) <= -10'sd26) begin
            s2_stk_d = |s1_q.sig;
         end else begin
            rwide_s  = {s1_q.sig, 26'd0} >> nsh_s;
            s2_mag_d = MW'(rwide_s[49:26]);
            s2_grd_d = rwide_s[25];
            s2_stk_d = |rwide_s[24:0];
         end
      end
   end

`ifdef FP2FIX_ROUND_EN
   assign inc_s = s2_grd_q & (s2_stk_q | s2_mag_q[0]);
`else
   assign inc_s = 1'b0;
`endif

   // S3: round, saturate by sign, apply two's complement, build flags
   always_comb begin
      rmag_s   = {1'b0, s2_mag_q} + {{MW{1'b0}}, inc_s};
      over_s   = s2_ovf_q | (s2_sign_q ? (rmag_s > NEG_LIM) : (rmag_s > POS_LIM));
      s3_fix_d = '0;
      s3_flg_d = 3'b000;
      case (s2_cls_q)
         NAN: begin
            s3_flg_d[FLG_NAN] = 1'b1;
         end
         INF: begin
            s3_fix_d          = s2_sign_q ? FIX_MIN : FIX_MAX;
            s3_flg_d[FLG_OVF] = 1'b1;
         end
         SUB: begin
            s3_flg_d[FLG_INX] = 1'b1;
         end
         NORM: begin
            if (over_s) begin
               s3_fix_d          = s2_sign_q ? FIX_MIN : FIX_MAX;
               s3_flg_d[FLG_OVF] = 1'b1;
            end else begin
               s3_fix_d          = s2_sign_q ? (W'(0) - rmag_s[W-1:0]) : rmag_s[W-1:0];
               s3_flg_d[FLG_INX] = s2_grd_q | s2_stk_q;
            end
         end
         default: begin
            s3_fix_d = '0;
            s3_flg_d = 3'b000;
         end
      endcase
   end

   // pipeline registers; reset drops every in-flight operand at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q    <= 1'b0;
         s2_v_q    <= 1'b0;
         s3_v_q    <= 1'b0;
         s1_q      <= '0;
         s2_sign_q <= 1'b0;
         s2_cls_q  <= ZERO;
         s2_mag_q  <= '0;
         s2_grd_q  <= 1'b0;
         s2_stk_q  <= 1'b0;
         s2_ovf_q  <= 1'b0;
         s3_fix_q  <= '0;
         s3_flg_q  <= 3'b000;
      end else begin
         if (s1_take_s) begin
            s1_v_q <= in_valid;
            if (in_valid) s1_q <= unp_s;
         end
         if (s2_take_s) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
               s2_sign_q <= s1_q.sign;
               s2_cls_q  <= s1_q.cls;
               s2_mag_q  <= s2_mag_d;
               s2_grd_q  <= s2_grd_d;
               s2_stk_q  <= s2_stk_d;
               s2_ovf_q  <= s2_ovf_d;
            end
         end
         if (s3_take_s) begin
            s3_v_q <= s2_v_q;
            if (s2_v_q) begin
               s3_fix_q <= s3_fix_d;
               s3_flg_q <= s3_flg_d;
            end
         end
      end
   end

   assign out_valid = s3_v_q;
   assign out_fix   = s3_fix_q;
   assign out_flags = s3_flg_q;

endmodule

// File: doc/fp2fix_pipe.md
# fp2fix_pipe

Pipelined IEEE-754 single-precision to signed fixed-point converter. It is the decode end of the float datapath: it takes packed 32-bit floats (for example, `fpadd_pipe` results) and returns two's-complement Qm.n values for integer-domain consumers and checkers. It has a 3-stage pipeline with valid/ready flow control on both sides, and handles saturation, NaN and rounding.

## Interface
Parameters:
- `INT_W`, default 16: integer bits of the result, sign included.
- `FRAC_W`, default 8: fraction bits of the result. `W = INT_W + FRAC_W`.

Ports:
- `clk`, input, 1: single clock; everything is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `in_fp` holds a valid operand.
- `in_ready`, output, 1: the converter accepts an operand this cycle.
- `in_fp`, input, 32: IEEE-754 single-precision operand.
- `out_valid`, output, 1: `out_fix`/`out_flags` are valid.
- `out_ready`, input, 1: the consumer takes the result this cycle.
- `out_fix`, output, W: signed fixed-point result, value × 2^FRAC_W.
- `out_flags`, output, 3: `{nan, ovf, inexact}`.

## Operation
- Transfer occurs when valid and ready are both high on the same edge, on either side.
- S1, unpack/classify:
  - Split sign, exponent e and mantissa.
  - Class is zero when e=0 and m=0.
  - Class is subnormal when e=0 and m≠0. Subnormals flush to 0 and set `inexact`.
  - Class is inf when e=255 and m=0; class is NaN when e=255 and m≠0.
  - Prepend the hidden 1 for normal numbers.
  - Shift amount `sh = e − 127 + FRAC_W − 23`, computed signed, 10 bits.
- S2, shift:
  - `sh ≥ 0`: left-shift the 24-bit significand into a (W+1)-bit magnitude. Any bit shifted beyond W+1 bits sets `ovf`.
  - `sh < 0`: right-shift and capture guard and sticky bits.
  - `sh ≤ −26`: result magnitude is 0, with guard=0 and sticky=1.
- S3, round/sign/saturate:
  - Rounding per the Configuration section.
  - Apply two's-complement negation when sign=1.
  - Saturate: positive magnitude > 2^(W−1)−1 gives `0x7F..F`; negative magnitude > 2^(W−1) gives `0x80..0`. Either case sets `ovf`.
  - Inf saturates by its sign and sets `ovf`.
  - NaN gives 0 and sets `nan` only.
  - `inexact` is set when guard|sticky is nonzero and no saturation occurred.
  - −0 converts to 0.
- Flags are per-result; they are not sticky.

## Timing
- Latency: a result is valid 3 cycles after acceptance when no stall occurs. Throughput is 1 per cycle.
- Each stage has a valid bit. A stage advances when its downstream stage is empty or is advancing.
- `in_ready = !s1_v | s1_adv` is combinational from `out_ready` through the stage valids; there is no combinational path from `in_valid` to `in_ready`.
- Stall: when `out_ready`=0 and `out_valid`=1, `out_fix`/`out_flags` stay stable until the transfer completes.
  - Up to 3 operands can be held in flight.
  - `in_ready` falls only once all three stages are full.
- A simultaneous accept and emit in a full pipeline sustains full throughput with no bubble.
- Reset:
  - All stage valids, `out_valid`, `out_fix` and `out_flags` are 0.
  - `in_ready` is 1 after reset is released.
- Reset asserted mid-stream discards all in-flight operands immediately (asynchronous); no partial result is emitted.
- Ordering: results leave in acceptance order.

## Configuration
- `FP2FIX_ROUND_EN` defined: round to nearest even on guard/sticky, using the kept LSB. A rounding carry that overflows the magnitude goes through saturation.
- Not defined: truncate toward zero (guard/sticky are dropped). `inexact` behaves identically in both builds.

## Structure
- Shared package `fp_pkg`:
  - Constants `FP_EXP_BIAS=127`, `FP_MANT_W=23`, `FP_EXP_W=8`.
  - Flag index constants `FLG_NAN`, `FLG_OVF`, `FLG_INX`.
  - Typedef `fp_class_t` with values ZERO/SUB/NORM/INF/NAN.
  - Packed struct `fp_unpacked_t`.
- Sub-module `fp_unpack` holds the combinational S1 classify/unpack logic; it is reusable by later float blocks.

## Test plan
Defaults: INT_W=16, FRAC_W=8.
- 267.0, `0x43858000`, streamed with `out_ready`=1 → `out_fix=0x010B00`, flags 000, `out_valid` exactly 3 cycles after accept.
- −10.25, `0xC1240000` → `0xFFF5C0`, flags 000. Zero, `0x00000000` → `0x000000`, flags 000.
- 70000.0, `0x4788B800` → `0x7FFFFF` with `ovf`; −inf, `0xFF800000` → `0x800000` with `ovf`; NaN, `0x7FC00000` → `0x000000` with `nan`.
- 1.5 LSB, `0x3BC00000` → `0x000002` with `inexact` when `FP2FIX_ROUND_EN` is defined; otherwise `0x000001` with `inexact`.
- Backpressure: send 5 operands back-to-back with `out_ready`=0 → `in_ready` low after 3 accepts and `out_fix` stable. Then release `out_ready` → all 5 results emerge in order, one per cycle.
- Assert `rst_n` low with 3 operands in flight → `out_valid`=0 immediately. After release, `in_ready`=1 and the next operand yields the correct result after 3 cycles.
